mode1_accum: RTL



---
 rtl/mode1_accum.sv | 86 ++++++++
 1 files changed

// File: rtl/mode1_accum.sv
// mode1_accum: accumulates NSAMP mode-1 cube results into a block sum/max/count and hands the block out on a valid/ready port.
// Ports: clk, rst (sync, active-high); in_valid/in_data/in_ready sample input; flush closes a partial block;
// out_valid/out_ready output handshake carrying out_sum, out_max, out_cnt, out_ovf.
// Optional feature: define MODE1_ACC_SAT_EN to saturate the accumulator and report a per-block overflow flag.
module mode1_accum #(
  parameter int NSAMP = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [11:0]      in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [11:0]      out_max,
  output logic [7:0]       out_cnt,
  output logic             out_ovf
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [ACC_W:0] sum_w;
  logic [11:0] mx, mx_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic take, close;
`ifdef MODE1_ACC_SAT_EN
  logic ovf, ovf_nxt;
`endif
  assign in_ready = state == ACCUM;
  assign out_valid = state == HOLD;
  always_comb begin
    take = in_valid && state == ACCUM;
    sum_w = {1'b0, acc} + {{(ACC_W-11){1'b0}}, in_data};
`ifdef MODE1_ACC_SAT_EN
    acc_nxt = take ? (sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0]) : acc;
    ovf_nxt = ovf | (take & sum_w[ACC_W]);
`else
    acc_nxt = take ? sum_w[ACC_W-1:0] : acc;
`endif
    mx_nxt = take && in_data > mx ? in_data : mx;
    cnt_nxt = cnt + 8'(take);
    close = state == ACCUM && ((take && cnt_nxt == 8'(NSAMP)) || (flush && cnt_nxt != 8'd0));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc <= '0;
      mx <= '0;
      cnt <= '0;
      out_sum <= '0;
      out_max <= '0;
      out_cnt <= '0;
`ifdef MODE1_ACC_SAT_EN
      ovf <= 1'b0;
      out_ovf <= 1'b0;
`endif
    end else if (state == HOLD) begin
      if (out_ready) state <= ACCUM;
    end else if (close) begin
      out_sum <= acc_nxt;
      out_max <= mx_nxt;
      out_cnt <= cnt_nxt;
      acc <= '0;
      mx <= '0;
      cnt <= '0;
`ifdef MODE1_ACC_SAT_EN
      out_ovf <= ovf_nxt;
      ovf <= 1'b0;
`endif
      state <= HOLD;
    end else begin
      acc <= acc_nxt;
      mx <= mx_nxt;
      cnt <= cnt_nxt;
`ifdef MODE1_ACC_SAT_EN
      ovf <= ovf_nxt;
`endif
    end
  end
`ifndef MODE1_ACC_SAT_EN
  assign out_ovf = 1'b0;
`endif
endmodule
